// File: rtl/border_anim_pkg.sv
// Shared definitions for the border animation sequencer and renderer.
// Ring codes and sequencer FSM states.
package border_anim_pkg;

    localparam logic [3:0] BORDER_BLANK = 4'd0;
    localparam logic [3:0] BORDER_RING1 = 4'd1;
    localparam logic [3:0] BORDER_RING2 = 4'd2;
    localparam logic [3:0] BORDER_RING3 = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        STEP1,
        STEP2,
        HOLD
    } seq_state_e;

    function automatic logic [3:0] ring_code(seq_state_e s);
        logic [3:0] code;
        code = BORDER_BLANK;
        unique case (s)
            IDLE:  code = BORDER_BLANK;
            STEP1: code = BORDER_RING1;
            STEP2: code = BORDER_RING2;
            HOLD:  code = BORDER_RING3;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/border_anim_sequencer_button_debouncer.sv
// Level debouncer: accepts a new level after DEBOUNCE_CYCLES
// consecutive cycles of disagreement; any agreement restarts the count.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock25mhz,
    input  logic reset_n,
    input  logic raw,
    output logic stable
);
    import border_anim_pkg::*;

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;

    // Count disagreeing cycles; flip the level on the last one.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (raw != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = raw;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Counter and accepted level registers.
    always_ff @(posedge clock25mhz or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/border_anim_sequencer.sv
// Border animation sequencer: press starts a 1->2->3 ring build-up.
// Define BORDER_SEQ_LOOP_EN to make HOLD time out back to STEP1.
module border_anim_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int STEP_CYCLES     = 25000000
) (
    input  logic       clock25mhz,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       clear,
    output logic [3:0] state,
    output logic       busy,
    output logic       done
);
    import border_anim_pkg::*;

    localparam int TW = $clog2(STEP_CYCLES);

    logic          btn_s1_q, btn_s2_q;
    logic          clr_s1_q, clr_s2_q;
    logic          btn_stable;
    logic          stable_d1_q;
    logic          press_q, press_d;
    seq_state_e    st_q, st_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          timer_last;
    logic [3:0]    state_q;
    logic          busy_q, done_q;

    // Two-flop synchronisers for both asynchronous inputs.
    always_ff @(posedge clock25mhz or negedge reset_n) begin
        if (!reset_n) begin
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            clr_s1_q <= 1'b0;
            clr_s2_q <= 1'b0;
        end else begin
            btn_s1_q <= btn_start;
            btn_s2_q <= btn_s1_q;
            clr_s1_q <= clear;
            clr_s2_q <= clr_s1_q;
        end
    end

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_db (
        .clock25mhz(clock25mhz),
        .reset_n   (reset_n),
        .raw       (btn_s2_q),
        .stable    (btn_stable)
    );

    assign press_d    = btn_stable & ~stable_d1_q;
    assign timer_last = (timer_q == TW'(STEP_CYCLES - 1));

    // Next state and timer; clear overrides press and expiry.
    always_comb begin
        st_d    = st_q;
        timer_d = timer_q;
        if (clr_s2_q) begin
            st_d    = IDLE;
            timer_d = '0;
        end else begin
            unique case (st_q)
                IDLE: begin
                    timer_d = '0;
                    if (press_q) st_d = STEP1;
                end
                STEP1: begin
                    if (timer_last) begin
                        st_d    = STEP2;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                STEP2: begin
                    if (timer_last) begin
                        st_d    = HOLD;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                HOLD: begin
`ifdef BORDER_SEQ_LOOP_EN
                    if (timer_last) begin
                        st_d    = STEP1;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
`else
                    timer_d = '0;
`endif
                end
            endcase
        end
    end

    // Edge detect, FSM state and registered outputs.
    always_ff @(posedge clock25mhz or negedge reset_n) begin
        if (!reset_n) begin
            stable_d1_q <= 1'b0;
            press_q     <= 1'b0;
            st_q        <= IDLE;
            timer_q     <= '0;
            state_q     <= BORDER_BLANK;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            stable_d1_q <= btn_stable;
            press_q     <= press_d;
            st_q        <= st_d;
            timer_q     <= timer_d;
            state_q     <= ring_code(st_d);
            busy_q      <= (st_d == STEP1) || (st_d == STEP2);
            done_q      <= (st_d == HOLD) && (st_q != HOLD);
        end
    end

    assign state = state_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: doc/border_anim_sequencer.md
Name: border_anim_sequencer

Overview:
- Upstream driver of the border-animation display stage. Produces the 4-bit `state` code consumed by the border renderer: 0 = blank, 1 = 1-px ring, 2 = 1+2-px rings, 3 = all three rings.
- A debounced pushbutton press starts a timed build-up 1→2→3, then holds at 3.
- A clear input returns the sequence to blank.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a button level change (10 ms at 25 MHz).
- STEP_CYCLES, 25000000, cycles spent in each build-up step before advancing (1 s at 25 MHz).

Ports:
- clock25mhz  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- btn_start  input  1  raw, asynchronous pushbutton; start request.
- clear  input  1  raw, asynchronous level; return to blank.
- state  output  4  animation code for the border renderer; values 0–3 only.
- busy  output  1  high while in STEP1 or STEP2.
- done  output  1  one-cycle pulse on entry to HOLD.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=0, busy=0, done=0.
  - FSM in IDLE, all counters 0, synchronisers 0, debounced level 0.
  - Release takes effect on the next clock edge.
- btn_start path:
  - 2-FF synchroniser → debouncer → rising-edge detector → registered one-cycle press_pulse.
  - The debouncer updates its stable level after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce resets its counter.
- clear path: 2-FF synchroniser only, no debounce. The level is acted on while high.
- Latency: a clean btn_start rise held stable sets state=1 exactly DEBOUNCE_CYCLES+4 rising edges after the first edge that samples it high.
  - Edges 1–2: synchroniser.
  - Edges 3..N+2: debounce count; stable level goes high at edge N+2.
  - Edge N+3: press_pulse.
  - Edge N+4: state.
- FSM states and transitions:
  - IDLE (state=0): press_pulse → STEP1; timer cleared.
  - STEP1 (state=1, busy=1): timer counts 0..STEP_CYCLES-1; at STEP_CYCLES-1 → STEP2 and timer cleared.
  - STEP2 (state=2, busy=1): same timing → HOLD; done=1 for exactly that transition cycle's following cycle (the first cycle state=3).
  - HOLD (state=3, busy=0): remains indefinitely.
- Clear: synchronised clear high in any state → IDLE next edge, timer cleared.
  - Clear has priority over press_pulse and over timer expiry in the same cycle.
  - While clear is held, the FSM stays in IDLE even if presses arrive.
- Press_pulse outside IDLE (STEP1, STEP2, HOLD) is ignored. No restart, no timer change.
- Timer width: $clog2(STEP_CYCLES). Debounce counter width: $clog2(DEBOUNCE_CYCLES+1). Neither counter may wrap. Both saturate or clear as described.
- Outputs are registered. state never takes values 4–15.
- Holding the button down produces exactly one press_pulse. Release does not generate a press.

Optional Feature:
- Macro: BORDER_SEQ_LOOP_EN.
- Defined: HOLD uses the timer too. After STEP_CYCLES cycles in HOLD the FSM returns to STEP1 (state 3→1), looping until clear. done pulses on every HOLD entry. Clear priority is unchanged.
- Undefined: HOLD is terminal until clear. The timer is idle in HOLD.

Decomposition:
- Shared package border_anim_pkg:
  - State encoding constants BORDER_BLANK=4'd0, BORDER_RING1=4'd1, BORDER_RING2=4'd2, BORDER_RING3=4'd3. The border renderer's case items use the same constants.
  - FSM state typedef: IDLE, STEP1, STEP2, HOLD.
- One sub-module: button_debouncer (params DEBOUNCE_CYCLES; ports clock25mhz, reset_n, raw, stable). It is instantiated once for btn_start. The sequencer itself does the edge detection.

Test Plan (DEBOUNCE_CYCLES=4, STEP_CYCLES=8):
- Reset mid-STEP2 (reset_n low for 3 cycles) → state=0, busy=0, done=0 immediately (asynchronous); after release the FSM stays in IDLE until the next press.
- Clean btn_start pulse held 20 cycles → state=1 at edge 8; busy=1 through state=2; state=3 at edge 24 with done=1 for one cycle; single press only.
- btn_start bouncing 1,0,1,0 each for 2 cycles then held high → exactly one press accepted; state=1 exactly 8 edges after the final stable rise is first sampled.
- Clear asserted in the same cycle the STEP1 timer expires → state=0 next edge (not 2); a press during held clear is ignored.
- Second press during STEP1 and during HOLD → no state change and no timer reset; state=3 timing is identical to a single press.
- BORDER_SEQ_LOOP_EN defined, one press, run 60 cycles → state sequence 1,2,3,1,2,3…; each step lasts 8 cycles; done pulses at each HOLD entry.
